// File: rtl/prog_loader_if.sv
// Loader bus bundle: host instruction stream, imem write port, core start/done and status.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the stream; imem and start are fire-and-forget.
//
// master: the loader (drives in_ready, imem_*, start and status outputs)
// slave : the environment (host stream source plus the core's done)
interface prog_loader_if #(
  parameter int IW = 9,
  parameter int AW = 8
);
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          start;
  logic          done;
  logic          busy;
  logic [AW:0]   load_count;
  logic [15:0]   run_cycles;
  logic          ok;
  logic          timeout_err;
  logic          overflow_err;

  modport master (
    input  in_valid, in_data, in_last, done,
    output in_ready, imem_we, imem_addr, imem_wdata, start,
           busy, load_count, run_cycles, ok, timeout_err, overflow_err
  );

  modport slave (
    output in_valid, in_data, in_last, done,
    input  in_ready, imem_we, imem_addr, imem_wdata, start,
           busy, load_count, run_cycles, ok, timeout_err, overflow_err
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams instructions into imem from addr 0, pulses start, waits for done/timeout.
// Latency: accepted word is written the cycle after accept; start follows the last write by one cycle.
// Backpressure: in_ready high only in IDLE/LOAD/FINISH; held low from last word until the run ends.
//
// Ports: clk_i, reset_i (sync, active-high); bus (prog_loader_if.master) carries the stream,
// imem write port, start/done and the status outputs (busy, load_count, run_cycles, ok, errors).
module prog_loader #(
  parameter int IW           = 9,
  parameter int AW           = 8,
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 4096
) (
  input  logic          clk_i,
  input  logic          reset_i,
  prog_loader_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_PULSE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [AW:0]  LAST_ADDR  = {1'b0, {AW{1'b1}}};
  localparam logic [15:0]  PULSE_LAST = 16'(START_CYCLES - 1);
  localparam logic [16:0]  TIMEOUT_L  = 17'(TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] wdata_q, wdata_d;
  logic          start_q, start_d;
  logic [15:0]   pulse_cnt_q, pulse_cnt_d;
  logic [AW:0]   load_cnt_q, load_cnt_d;
  logic [15:0]   run_q, run_d;
  logic          ok_q, ok_d;
  logic          to_q, to_d;
  logic          ovf_q, ovf_d;

  logic          accept;
  logic          first_word;
  logic [AW:0]   wr_base;
  logic          at_top;
  logic [16:0]   run_next;

  always_comb begin
    accept     = bus.in_valid && in_ready_q;
    // A word accepted in IDLE or FINISH starts a new program at address 0.
    first_word = (state_q == S_IDLE) || (state_q == S_FINISH);
    wr_base    = first_word ? '0 : load_cnt_q;
    at_top     = (wr_base == LAST_ADDR);
    run_next   = {1'b0, run_q} + 17'd1;

    state_d     = state_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    start_d     = start_q;
    pulse_cnt_d = pulse_cnt_q;
    load_cnt_d  = load_cnt_q;
    run_d       = run_q;
    ok_d        = ok_q;
    to_d        = to_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE, S_LOAD, S_FINISH: begin
        if (accept) begin
          we_d       = 1'b1;
          addr_d     = wr_base[AW-1:0];
          wdata_d    = bus.in_data;
          load_cnt_d = wr_base + 1'b1;
          if (first_word) begin
            ok_d  = 1'b0;
            to_d  = 1'b0;
            ovf_d = 1'b0;
            run_d = '0;
          end
          // The top address closes the program even without in_last; the pointer never wraps.
          if (bus.in_last || at_top) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_LOAD;
          end
          if (at_top && !bus.in_last) begin
            ovf_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Final write is on the imem port this cycle; start only rises after it.
        state_d     = S_PULSE;
        start_d     = 1'b1;
        pulse_cnt_d = '0;
      end
      S_PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d = S_WAIT;
          start_d = 1'b0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        // done is checked first so it wins over a timeout in the same cycle.
        if (bus.done) begin
          state_d = S_FINISH;
          ok_d    = 1'b1;
        end else begin
          if (run_q != 16'hFFFF) begin
            run_d = run_q + 16'd1;
          end
          if (run_next >= TIMEOUT_L) begin
            state_d = S_FINISH;
            to_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_FINISH);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_FINISH));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      start_q     <= 1'b0;
      pulse_cnt_q <= '0;
      load_cnt_q  <= '0;
      run_q       <= '0;
      ok_q        <= 1'b0;
      to_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      start_q     <= start_d;
      pulse_cnt_q <= pulse_cnt_d;
      load_cnt_q  <= load_cnt_d;
      run_q       <= run_d;
      ok_q        <= ok_d;
      to_q        <= to_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.imem_we      = we_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.start        = start_q;
  assign bus.busy         = busy_q;
  assign bus.load_count   = load_cnt_q;
  assign bus.run_cycles   = run_q;
  assign bus.ok           = ok_q;
  assign bus.timeout_err  = to_q;
  assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: scoreboarded imem writes plus per-scenario inline checks.
// Latency: n/a.
// Backpressure: stimulus waits on in_ready before presenting each word to an edge.
module tb_prog_loader;
  localparam int IW = 9;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if #(.IW(IW), .AW(AW)) bm ();
  prog_loader_if #(.IW(IW), .AW(AW)) bt ();

  // Second instance with a short timeout sees the same stream; its core never finishes.
  assign bt.in_valid = bm.in_valid;
  assign bt.in_data  = bm.in_data;
  assign bt.in_last  = bm.in_last;
  assign bt.done     = 1'b0;

  prog_loader #(.IW(IW), .AW(AW)) dut (
    .clk_i(clk), .reset_i(reset), .bus(bm.master)
  );
  prog_loader #(.IW(IW), .AW(AW), .TIMEOUT(16)) dut_t (
    .clk_i(clk), .reset_i(reset), .bus(bt.master)
  );

  int checks = 0;
  int passed = 0;
  int wr_seen = 0;
  logic [AW+IW-1:0] exp_q[$];

  // Write monitor: every imem write must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    logic [AW+IW-1:0] e;
    if (bm.imem_we === 1'b1) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected: got addr %0d data %h, no write expected", bm.imem_addr, bm.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bm.imem_addr, bm.imem_wdata} !== e)
          $display("FAIL wr_data: got addr %0d data %h, want addr %0d data %h",
                   bm.imem_addr, bm.imem_wdata, e[AW+IW-1:IW], e[IW-1:0]);
        else passed++;
      end
    end
    if (bm.start === 1'b1) begin
      checks++;
      if (bm.imem_we !== 1'b0) $display("FAIL start_vs_we: imem_we=%b while start=1, want 0", bm.imem_we);
      else passed++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [AW-1:0] a, input logic [IW-1:0] d, input logic l);
    int n;
    n = 0;
    bm.in_valid = 1'b1;
    bm.in_data  = d;
    bm.in_last  = l;
    while (bm.in_ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      $display("FAIL send_wait: in_ready=0 for 400 cycles at addr %0d, want 1", a);
    end else begin
      exp_q.push_back({a, d});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bm.in_valid = 1'b0;
    bm.in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    bm.in_valid = 1'b0;
    bm.in_last  = 1'b0;
    bm.done     = 1'b0;
    reset       = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d writes outstanding, want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    bm.in_valid = 1'b0; bm.in_data = '0; bm.in_last = 1'b0; bm.done = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bm.in_ready, bm.imem_we, bm.start, bm.busy, bm.ok, bm.timeout_err, bm.overflow_err} !== 7'b1000000)
      $display("FAIL reset_flags: got rdy/we/start/busy/ok/to/ovf=%b want 1000000",
               {bm.in_ready, bm.imem_we, bm.start, bm.busy, bm.ok, bm.timeout_err, bm.overflow_err});
    else passed++;
    checks++;
    if ({bm.load_count, bm.run_cycles, bm.imem_addr} !== '0)
      $display("FAIL reset_counts: got load=%0d run=%0d addr=%0d want 0", bm.load_count, bm.run_cycles, bm.imem_addr);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_load6();
    for (int i = 0; i < 6; i++) begin
      send_word(8'(i), 9'(i * 37 + 5), (i == 5));
      checks++;
      if ({bm.imem_we, bm.imem_addr, bm.busy} !== {1'b1, 8'(i), 1'b1})
        $display("FAIL load6_wr%0d: got we=%b addr=%0d busy=%b want 1/%0d/1", i, bm.imem_we, bm.imem_addr, bm.busy, i);
      else passed++;
    end
    bm.in_valid = 1'b0;
    bm.in_last  = 1'b0;
    checks++;
    if ({bm.in_ready, bm.start} !== 2'b00)
      $display("FAIL load6_drain: got rdy=%b start=%b want 0/0", bm.in_ready, bm.start);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({bm.start, bm.imem_we, bm.busy} !== 3'b101)
      $display("FAIL load6_start: got start=%b we=%b busy=%b want 1/0/1", bm.start, bm.imem_we, bm.busy);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({bm.start, bm.busy, bm.run_cycles} !== {2'b01, 16'd0})
      $display("FAIL load6_startfall: got start=%b busy=%b run=%0d want 0/1/0", bm.start, bm.busy, bm.run_cycles);
    else passed++;
  endtask

  task automatic test_done();
    repeat (20) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({bm.busy, bm.ok, bm.run_cycles} !== {2'b10, 16'd20})
      $display("FAIL done_pre: got busy=%b ok=%b run=%0d want 1/0/20", bm.busy, bm.ok, bm.run_cycles);
    else passed++;
    bm.done = 1'b1;
    @(posedge clk); #1;
    bm.done = 1'b0;
    checks++;
    if ({bm.ok, bm.timeout_err, bm.busy, bm.in_ready} !== 4'b1001)
      $display("FAIL done_finish: got ok/to/busy/rdy=%b want 1001", {bm.ok, bm.timeout_err, bm.busy, bm.in_ready});
    else passed++;
    checks++;
    if (bm.run_cycles !== 16'd20) $display("FAIL done_run: got %0d want 20", bm.run_cycles);
    else passed++;
    idle(3);
    checks++;
    if ({bm.ok, bm.run_cycles, bm.load_count} !== {1'b1, 16'd20, 9'd6})
      $display("FAIL done_hold: got ok=%b run=%0d load=%0d want 1/20/6", bm.ok, bm.run_cycles, bm.load_count);
    else passed++;
  endtask

  task automatic test_reload();
    send_word(8'd0, 9'h1AB, 1'b0);
    checks++;
    if ({bm.ok, bm.run_cycles, bm.load_count, bm.busy} !== {1'b0, 16'd0, 9'd1, 1'b1})
      $display("FAIL reload_clear: got ok=%b run=%0d load=%0d busy=%b want 0/0/1/1", bm.ok, bm.run_cycles, bm.load_count, bm.busy);
    else passed++;
    send_word(8'd1, 9'h0CD, 1'b1);
    idle(2);
    checks++;
    if (bm.load_count !== 9'd2) $display("FAIL reload_count: got %0d want 2", bm.load_count);
    else passed++;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    for (int i = 0; i < 3; i++) send_word(8'(i), 9'(300 + i), (i == 2));
    bm.in_valid = 1'b0;
    bm.in_last  = 1'b0;
    n = 0;
    while (bt.start !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    while (bt.start !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 10) begin
      checks++;
      $display("FAIL to_start: start pulse not seen within bound, waited %0d cycles", n);
    end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 15) begin
        checks++;
        if ({bt.timeout_err, bt.busy, bt.run_cycles} !== {2'b01, 16'd15})
          $display("FAIL to_pre: got to=%b busy=%b run=%0d want 0/1/15", bt.timeout_err, bt.busy, bt.run_cycles);
        else passed++;
      end
    end
    checks++;
    if ({bt.timeout_err, bt.ok, bt.busy, bt.in_ready} !== 4'b1001)
      $display("FAIL to_flags: got to/ok/busy/rdy=%b want 1001", {bt.timeout_err, bt.ok, bt.busy, bt.in_ready});
    else passed++;
    checks++;
    if (bt.run_cycles !== 16'd16) $display("FAIL to_run: got %0d want 16", bt.run_cycles);
    else passed++;
  endtask

  task automatic test_overflow();
    int wr0;
    logic saw_start;
    do_reset();
    wr0 = wr_seen;
    for (int i = 0; i < 256; i++) send_word(8'(i), 9'(i) ^ 9'h15A, 1'b0);
    checks++;
    if ({bm.in_ready, bm.overflow_err, bm.busy, bm.load_count} !== {3'b011, 9'd256})
      $display("FAIL ovf_state: got rdy=%b ovf=%b busy=%b load=%0d want 0/1/1/256",
               bm.in_ready, bm.overflow_err, bm.busy, bm.load_count);
    else passed++;
    bm.in_valid = 1'b1;
    bm.in_data  = 9'h1FF;
    bm.in_last  = 1'b0;
    saw_start   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bm.start === 1'b1) saw_start = 1'b1;
      checks++;
      if (bm.in_ready !== 1'b0) $display("FAIL ovf_holdoff%0d: in_ready=%b want 0", k, bm.in_ready);
      else passed++;
    end
    bm.in_valid = 1'b0;
    checks++;
    if (saw_start !== 1'b1) $display("FAIL ovf_start: start seen=%b want 1", saw_start);
    else passed++;
    checks++;
    if (wr_seen - wr0 !== 256) $display("FAIL ovf_writes: got %0d writes want 256", wr_seen - wr0);
    else passed++;
  endtask

  task automatic test_gaps();
    int wr0;
    do_reset();
    wr0 = wr_seen;
    for (int i = 0; i < 4; i++) begin
      send_word(8'(i), 9'(i * 3 + 100), (i == 3));
      idle(2);
    end
    idle(3);
    checks++;
    if (wr_seen - wr0 !== 4) $display("FAIL gaps_writes: got %0d writes want 4", wr_seen - wr0);
    else passed++;
    checks++;
    if (bm.load_count !== 9'd4) $display("FAIL gaps_count: got %0d want 4", bm.load_count);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) send_word(8'(i), 9'(i + 17), 1'b0);
    bm.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bm.imem_we, bm.busy, bm.in_ready, bm.load_count} !== {3'b001, 9'd0})
      $display("FAIL rstmid_state: got we=%b busy=%b rdy=%b load=%0d want 0/0/1/0",
               bm.imem_we, bm.busy, bm.in_ready, bm.load_count);
    else passed++;
    reset = 1'b0;
    send_word(8'd0, 9'h055, 1'b0);
    checks++;
    if ({bm.imem_we, bm.imem_addr} !== {1'b1, 8'd0})
      $display("FAIL rstmid_reload: got we=%b addr=%0d want 1/0", bm.imem_we, bm.imem_addr);
    else passed++;
    send_word(8'd1, 9'h0AA, 1'b1);
    idle(3);
    checks++;
    if ({bm.load_count, exp_q.size() == 0} !== {9'd2, 1'b1})
      $display("FAIL rstmid_done: got load=%0d pending=%0d want 2/0", bm.load_count, exp_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load6();
    test_done();
    test_reload();
    test_timeout();
    test_overflow();
    test_gaps();
    test_reset_mid();
    do_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
